// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Four-phase (IDLE/READ/EXEC/WB) ALU execution unit driving an
//               external 4 x 32-bit register file; one instruction per 4 clks.
// Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [1:0]  rs,
    input  logic [1:0]  rt,
    input  logic [1:0]  rd,
    output logic [1:0]  read_reg1,
    output logic [1:0]  read_reg2,
    input  logic [31:0] rd1_data,
    input  logic [31:0] rd2_data,
    output logic [31:0] write_data,
    output logic [1:0]  write_reg,
    output logic        reg_write,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf,
    output logic        done
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [2:0]  r_op_q,    w_op_d;
    logic [1:0]  r_rs_q,    w_rs_d;
    logic [1:0]  r_rt_q,    w_rt_d;
    logic [1:0]  r_rd_q,    w_rd_d;
    logic [31:0] r_a_q,     w_a_d;
    logic [31:0] r_b_q,     w_b_d;
    logic [31:0] r_result_q, w_result_d;
    logic        r_zero_q,  w_zero_d;
    logic        r_ovf_q,   w_ovf_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic [1:0]  r_wreg_q,  w_wreg_d;
    logic        r_regwr_q, w_regwr_d;
    logic        r_done_q,  w_done_d;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_lt;
    logic [31:0] w_alu;
    logic        w_alu_ovf;

    assign w_sum  = r_a_q + r_b_q;
    assign w_diff = r_a_q - r_b_q;
    assign w_lt   = $signed(r_a_q) < $signed(r_b_q);

    always_comb begin
        w_alu     = 32'd0;
        w_alu_ovf = 1'b0;
        case (r_op_q)
            c_OP_ADD: begin
                w_alu     = w_sum;
                w_alu_ovf = (r_a_q[31] == r_b_q[31]) && (w_sum[31] != r_a_q[31]);
            end
            c_OP_SUB: begin
                w_alu     = w_diff;
                w_alu_ovf = (r_a_q[31] != r_b_q[31]) && (w_diff[31] != r_a_q[31]);
            end
            c_OP_AND: w_alu = r_a_q & r_b_q;
            c_OP_OR:  w_alu = r_a_q | r_b_q;
            c_OP_XOR: w_alu = r_a_q ^ r_b_q;
            c_OP_SLT: w_alu = {31'd0, w_lt};
            c_OP_SLL: w_alu = r_a_q << r_b_q[4:0];
            default:  w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_rs_d     = r_rs_q;
        w_rt_d     = r_rt_q;
        w_rd_d     = r_rd_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
        w_ovf_d    = r_ovf_q;
        w_wdata_d  = r_wdata_q;
        w_wreg_d   = r_wreg_q;
        w_regwr_d  = 1'b0;
        w_done_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_d = S_READ;
                    w_op_d    = op;
                    w_rs_d    = rs;
                    w_rt_d    = rt;
                    w_rd_d    = rd;
                end
            end
            S_READ: begin
                w_a_d     = rd1_data;
                w_b_d     = rd2_data;
                w_state_d = S_EXEC;
            end
            S_EXEC: begin
                // Writeback controls are registered here so they are clean for all of WB.
                w_result_d = w_alu;
                w_zero_d   = (w_alu == 32'd0);
                w_ovf_d    = w_alu_ovf;
                w_wdata_d  = w_alu;
                w_wreg_d   = r_rd_q;
                w_regwr_d  = (r_op_q != c_OP_NOP);
                w_done_d   = 1'b1;
                w_state_d  = S_WB;
            end
            S_WB: begin
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q  <= S_IDLE;
            r_op_q     <= 3'd0;
            r_rs_q     <= 2'd0;
            r_rt_q     <= 2'd0;
            r_rd_q     <= 2'd0;
            r_a_q      <= 32'd0;
            r_b_q      <= 32'd0;
            r_result_q <= 32'd0;
            r_zero_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_wdata_q  <= 32'd0;
            r_wreg_q   <= 2'd0;
            r_regwr_q  <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_rs_q     <= w_rs_d;
            r_rt_q     <= w_rt_d;
            r_rd_q     <= w_rd_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
            r_ovf_q    <= w_ovf_d;
            r_wdata_q  <= w_wdata_d;
            r_wreg_q   <= w_wreg_d;
            r_regwr_q  <= w_regwr_d;
            r_done_q   <= w_done_d;
        end
    end

    assign in_ready   = (r_state_q == S_IDLE);
    assign read_reg1  = r_rs_q;
    assign read_reg2  = r_rt_q;
    assign write_data = r_wdata_q;
    assign write_reg  = r_wreg_q;
    assign reg_write  = r_regwr_q;
    assign result     = r_result_q;
    assign zero       = r_zero_q;
    assign ovf        = r_ovf_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameters: none; all widths fixed (4-entry x 32-bit register file, 2-bit register index).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
REQ-004 in_valid  in  1  instruction offered this cycle.
REQ-005 in_ready  out  1  unit can accept an instruction; high only in IDLE.
REQ-006 op  in  3  operation code, sampled on accept.
REQ-007 rs, rt, rd  in  2 each  source 1, source 2, destination register indices, sampled on accept.
REQ-008 read_reg1, read_reg2  out  2 each  read addresses driven to register file.
REQ-009 rd1_data, rd2_data  in  32 each  combinational read data returned by register file.
REQ-010 write_data  out  32  writeback value to register file.
REQ-011 write_reg  out  2  writeback register index.
REQ-012 reg_write  out  1  writeback enable to register file.
REQ-013 result  out  32  last computed result, held until next EXEC.
REQ-014 zero, ovf  out  1 each  flags of last result, held with result.
REQ-015 done  out  1  one-cycle pulse on instruction retirement.

Function
REQ-016 FSM states IDLE, READ, EXEC, WB; transitions IDLE->READ on in_valid&&in_ready, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-017 Accept at edge k; operands captured at edge k+1; result/flags registered at edge k+2; done high and reg_write high during cycle k+2..k+3; IDLE at k+3.
REQ-018 Throughput: one instruction per 4 cycles; in_valid ignored outside IDLE; op/rs/rt/rd latched internally, input changes after accept have no effect.
REQ-019 read_reg1=latched rs, read_reg2=latched rt from READ entry until next accept; 0 after reset.
REQ-020 Ops: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SLT signed (result 1 or 0), 110 SLL a by b[4:0], 111 NOP.
REQ-021 Arithmetic modulo 2^32; carry discarded.
REQ-022 ovf=1 only for ADD/SUB signed overflow (operands same sign for ADD / differing sign for SUB, result sign differs from a); 0 for all other ops.
REQ-023 zero=1 iff 32-bit result == 0; NOP yields result 0, zero=1, ovf=0.
REQ-024 In WB: write_data=result, write_reg=latched rd, reg_write=1 for exactly one cycle; NOP keeps reg_write=0 but still pulses done.
REQ-025 reg_write, write_reg, write_data change only at rising clk and are stable throughout WB.
REQ-026 Outside WB reg_write=0; write_reg/write_data hold last values.
REQ-027 Back-to-back dependent instructions (next rs/rt == previous rd) read the written value; no bypass needed since writeback completes before next READ.
REQ-028 rd equal to rs or rt permitted; source values are those read in READ.

Reset
REQ-029 reset low: FSM to IDLE, in_ready=1, done=0, reg_write=0, read_reg1/2=0, write_reg=0, write_data=0, result=0, zero=0, ovf=0.
REQ-030 Reset mid-operation aborts the instruction; no reg_write pulse, no done pulse for it.
REQ-031 First accept possible on first rising edge after reset deasserts.

Verification
REQ-032 Preload r1=5, r2=3; ADD rs=1 rt=2 rd=3 -> reg_write one cycle at k+2, write_reg=3, write_data=8, done pulse, r3 reads 8.
REQ-033 r1=0x7FFFFFFF, r2=1: ADD -> result 0x80000000, ovf=1; SUB r2-r2 -> result 0, zero=1, ovf=0.
REQ-034 r1=0xFFFFFFFF (-1), r2=1: SLT rs=1 rt=2 -> 1; SLL r2 by r1 (shamt 31) -> 0x80000000.
REQ-035 in_valid held high with changing op during READ/EXEC/WB -> only one accept per 4 cycles, in_ready low 3 cycles; NOP -> done pulses, reg_write stays 0.
REQ-036 Dependent chain: ADD rd=1 then ADD rs=1 -> second uses updated r1; reset low during EXEC -> no write, all outputs per REQ-029.
